wallace_multiplier_pipe: RTL and testbench
==========================================

Name: wallace_multiplier_pipe

Overview:
Parametrised, pipelined successor to the 8x8 Wallace-tree multiplier. It accepts WIDTH x WIDTH operands in either unsigned or signed (two's-complement) mode. The partial-product tree is reduced across STAGES registered levels, and results carry a valid/ready handshake with full-pipeline stall. It sits between the operand-issue logic and the result consumer in the datapath.

Parameters:
WIDTH, 8, operand width in bits; legal range 4..32.
STAGES, 2, number of register levels from operand capture to result; legal range 1..4; also the latency in cycles.

Ports:
clk  input  1  system clock; all logic is rising-edge.
rst  input  1  synchronous, active-high reset.
in1  input  WIDTH  multiplicand.
in2  input  WIDTH  multiplier.
sgn  input  1  operand mode, sampled together with in1/in2: 1 = signed two's-complement, 0 = unsigned.
in_valid  input  1  in1/in2/sgn are valid this cycle.
in_ready  output  1  the block accepts the operand set this cycle.
out  output  2*WIDTH  product.
out_valid  output  1  out holds an unconsumed result.
out_ready  input  1  the consumer takes out this cycle.

Behaviour:
- Reset (rst=1 at a clk edge):
  - all stage valid bits clear; out_valid=0; out=0.
  - in_ready=1 from the first cycle after reset.
  - Reset mid-operation discards every in-flight operand. The cycle after reset has no residual valid.
- Advance condition: adv = !(out_valid && !out_ready). in_ready = adv (combinational, no in_valid dependency).
- Acceptance: an operand set is accepted when in_valid && in_ready. On acceptance, stage 1 captures in1, in2 and sgn plus valid=1. If in_valid=0 while adv=1, stage 1 captures valid=0 (a bubble).
- Pipeline movement: when adv=1, every stage loads from its predecessor. When adv=0, all stages, out and out_valid hold unchanged. Bubbles are not collapsed.
- Latency: a set accepted at edge N produces out_valid=1 with its product after edge N+STAGES-1, provided there is no stall. Stall cycles add one-for-one.
- Throughput: one result per cycle when out_ready is held at 1.
- Output register:
  - is the last stage, and out_valid is its valid bit.
  - when the last stage receives a bubble, out_valid drops to 0 and out keeps its previous value.
  - out_valid && out_ready with an incoming valid gives back-to-back results with no dead cycle.
- Arithmetic:
  - Full-precision product in 2*WIDTH bits; there is no truncation or overflow.
  - sgn=0: unsigned product.
  - sgn=1: two's-complement product. Partial products use Baugh-Wooley (complemented sign terms plus correction constant). The reduction is a Wallace tree of full and half adders, finished by a final carry-propagate adder.
  - Tree levels are split as evenly as possible across the STAGES registers. The final adder sits in the last stage.
- sgn travels with its operand set. Mixed-mode back-to-back issue is legal.
- No X propagation: stage data registers may hold stale values, but out only changes on an adv edge.

Test Plan:
- Reset then single unsigned op, WIDTH=8, STAGES=2: in1=0x70, in2=0x08, sgn=0. Required: out=0x0380, out_valid=1 exactly 2 edges after acceptance; out_valid drops the next cycle if no new input.
- Corner products, WIDTH=8:
  - unsigned 0xFF*0xFF -> 0xFE01
  - signed 0xFF*0xFF -> 0x0001
  - signed 0x80*0x80 -> 0x4000
  - signed 0x80*0x7F -> 0xC080
  - signed 0x05*0xFD -> 0xFFF1
- Streaming: in1=0x70, in2 stepping 0x01..0x07 on consecutive cycles, out_ready=1. Required: out sequence 0x0070, 0x00E0, ... 0x0310 on 7 consecutive cycles with no gaps.
- Backpressure: hold out_ready=0 for 3 cycles while a result is valid. Required: in_ready=0, out stable for those 3 cycles, no result lost or duplicated, order preserved after release.
- Reset mid-stream: assert rst with 2 ops in flight. Required: out_valid=0, out=0 the next cycle and no stale result appears later.
- Parameter sweep: WIDTH in {4, 8, 16} x STAGES in {1, 3, 4}, random operands with random sgn and out_ready. Required: every out matches the reference product and latency equals STAGES plus stall cycles.

Source files
------------

// File: rtl/wallace_multiplier_pipe.sv
// Pipelined WIDTH x WIDTH multiplier, unsigned or signed per operand set, with a Baugh-Wooley
// partial-product array reduced by a carry-save Wallace tree and a valid/ready output stage.
module wallace_multiplier_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   in1,
    input  logic [WIDTH-1:0]   in2,
    input  logic               sgn,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [2*WIDTH-1:0] out,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam int PW  = 2 * WIDTH;
    localparam int NR  = WIDTH + 1;
    localparam int SEG = STAGES - 1;

    // Signed mode folds the negative weights of the sign rows into one constant row.
    localparam logic [PW-1:0] CORR = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));

    typedef logic [NR-1:0][PW-1:0] rows_t;

    function automatic int rows_after(input int levels);
        int n;
        n = NR;
        for (int k = 0; k < levels; k++) n = 2 * (n / 3) + n % 3;
        return n;
    endfunction

    function automatic int tree_depth(input int rows);
        int n;
        int d;
        n = rows;
        d = 0;
        while (n > 2) begin
            n = 2 * (n / 3) + n % 3;
            d++;
        end
        return d;
    endfunction

    localparam int NL = tree_depth(NR);

    // Register stage (2..STAGES-1) sitting after tree level lvl, or 0 when lvl is not a cut.
    function automatic int cut_stage(input int lvl);
        for (int s = 1; s < SEG; s++) begin
            if ((s * NL) / SEG == lvl) return s + 1;
        end
        return 0;
    endfunction

    function automatic rows_t pp_gen(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                     input logic s);
        rows_t r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                r[i][i+j] = (a[j] & b[i]) ^ (s & ((i == WIDTH - 1) != (j == WIDTH - 1)));
            end
        end
        if (s) r[NR-1] = CORR;
        return r;
    endfunction

    // One Wallace level: each group of three rows becomes a sum row and a shifted carry row.
    // Columns where one input row is zero reduce to half adders after constant propagation.
    function automatic rows_t csa_level(input rows_t r, input int n);
        rows_t o;
        int    g;
        o = '0;
        g = n / 3;
        for (int i = 0; i < g; i++) begin
            o[2*i]   = r[3*i] ^ r[3*i+1] ^ r[3*i+2];
            o[2*i+1] = ((r[3*i] & r[3*i+1]) | (r[3*i] & r[3*i+2]) | (r[3*i+1] & r[3*i+2])) << 1;
        end
        for (int i = 0; i < n % 3; i++) o[2*g+i] = r[3*g+i];
        return o;
    endfunction

    logic              adv;
    logic              last_in;
    logic [STAGES:1]   vld;
    rows_t             node [NL+1];
    logic [PW-1:0]     prod;

    assign adv       = !(out_valid && !out_ready);
    assign in_ready  = adv;
    assign out_valid = vld[STAGES];

    if (STAGES == 1) begin : g_pp_comb
        assign node[0] = pp_gen(in1, in2, sgn);
        assign last_in = in_valid;
    end else begin : g_pp_reg
        logic [WIDTH-1:0] a_q;
        logic [WIDTH-1:0] b_q;
        logic             s_q;

        always_ff @(posedge clk) begin
            if (adv && in_valid) begin
                a_q <= in1;
                b_q <= in2;
                s_q <= sgn;
            end
        end

        assign node[0] = pp_gen(a_q, b_q, s_q);
        assign last_in = vld[STAGES-1];
    end

    for (genvar k = 1; k <= NL; k++) begin : g_lvl
        rows_t red;
        assign red = csa_level(node[k-1], rows_after(k - 1));

        if (cut_stage(k) != 0) begin : g_cut
            rows_t q;
            always_ff @(posedge clk) begin
                if (adv && vld[cut_stage(k)-1]) q <= red;
            end
            assign node[k] = q;
        end else begin : g_thru
            assign node[k] = red;
        end
    end

    assign prod = node[NL][0] + node[NL][1];

    // Valid bits march with adv; bubbles are kept so latency stays fixed at STAGES.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
            out <= '0;
        end else if (adv) begin
            vld[1] <= in_valid;
            for (int s = 2; s <= STAGES; s++) vld[s] <= vld[s-1];
            if (last_in) out <= prod;
        end
    end

endmodule

// File: tb/tb_wallace_multiplier_pipe.sv
// Bench for wallace_multiplier_pipe: directed vectors and sequences on an 8x8/2-stage
// instance, plus randomized traffic on a WIDTH x STAGES sweep against an arithmetic model.
module tb_wallace_multiplier_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [63:0] p;
        int          e;
    } exp_t;

    typedef struct packed {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        s;
        logic [15:0] p;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [63:0] ref_mul(input int w, input logic [31:0] a,
                                            input logic [31:0] b, input logic s);
        longint ai;
        longint bi;
        longint p;
        logic [63:0] m;
        ai = longint'({32'd0, a});
        bi = longint'({32'd0, b});
        if (s && a[w-1]) ai = ai - (longint'(1) << w);
        if (s && b[w-1]) bi = bi - (longint'(1) << w);
        p = ai * bi;
        m = (64'd1 << (2 * w)) - 64'd1;
        return 64'(p) & m;
    endfunction

    // ---------------- main 8x8, 2-stage instance ----------------
    logic        rst, in_valid, sgn, out_ready, in_ready, out_valid;
    logic [7:0]  in1, in2;
    logic [15:0] out;

    wallace_multiplier_pipe #(.WIDTH(8), .STAGES(2)) u_dut (
        .clk(clk), .rst(rst), .in1(in1), .in2(in2), .sgn(sgn), .in_valid(in_valid),
        .in_ready(in_ready), .out(out), .out_valid(out_valid), .out_ready(out_ready)
    );

    logic [63:0] q[$];
    logic        stall_prev;
    logic [15:0] stall_out;

    task automatic step(input logic iv, input logic [7:0] a, input logic [7:0] b,
                        input logic s, input logic ordy);
        logic [63:0] e;
        @(negedge clk);
        in_valid  = iv;
        in1       = a;
        in2       = b;
        sgn       = s;
        out_ready = ordy;
        #1;
        chk("in_ready_rule", 64'(in_ready), 64'(!(out_valid && !out_ready)));
        if (stall_prev) begin
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_out", 64'(out), 64'(stall_out));
        end
        stall_prev = out_valid && !out_ready;
        stall_out  = out;
        if (out_valid && out_ready) begin
            if (q.size() == 0) chk("spurious_result", 64'(out_valid), 64'd0);
            else begin
                e = q.pop_front();
                chk("result", 64'(out), e);
            end
        end
        if (iv && in_ready) q.push_back(ref_mul(8, 32'(a), 32'(b), s));
    endtask

    // ---------------- parameter sweep ----------------
    logic sweep_go   = 1'b0;
    int   sweep_done = 0;

    for (genvar wi = 0; wi < 3; wi++) begin : g_w
        for (genvar si = 0; si < 3; si++) begin : g_s
            localparam int W = (wi == 0) ? 4 : (wi == 1) ? 8 : 16;
            localparam int S = (si == 0) ? 1 : (si == 1) ? 3 : 4;

            logic           r, iv, s, ordy, irdy, ov;
            logic [W-1:0]   a, b;
            logic [2*W-1:0] o;
            exp_t           sq[$];
            int             adv_cnt;

            wallace_multiplier_pipe #(.WIDTH(W), .STAGES(S)) u_sw (
                .clk(clk), .rst(r), .in1(a), .in2(b), .sgn(s), .in_valid(iv),
                .in_ready(irdy), .out(o), .out_valid(ov), .out_ready(ordy)
            );

            initial begin
                exp_t  x;
                logic  adv;
                int    e;
                string tag;
                tag = $sformatf("sw_w%0d_s%0d", W, S);
                r = 1'b1; iv = 1'b0; s = 1'b0; ordy = 1'b0; a = '0; b = '0;
                adv_cnt = 0;
                wait (sweep_go);
                repeat (2) @(negedge clk);
                r = 1'b0;
                #1;
                chk({tag, "_rst_valid"}, 64'(ov), 64'd0);
                for (int c = 0; c < 400; c++) begin
                    @(negedge clk);
                    if (c < 380) begin
                        iv   = ($urandom_range(0, 9) < 7);
                        a    = W'($urandom);
                        b    = W'($urandom);
                        s    = 1'($urandom);
                        ordy = ($urandom_range(0, 3) != 0);
                    end else begin
                        iv   = 1'b0;
                        ordy = 1'b1;
                    end
                    #1;
                    adv = !(ov && !ordy);
                    chk({tag, "_in_ready"}, 64'(irdy), 64'(adv));
                    e = adv_cnt + 1;
                    if (ov && ordy) begin
                        if (sq.size() == 0) chk({tag, "_spurious"}, 64'(ov), 64'd0);
                        else begin
                            x = sq.pop_front();
                            chk({tag, "_prod"}, 64'(o), x.p);
                            chk({tag, "_latency"}, 64'(e - x.e), 64'(S));
                        end
                    end
                    if (iv && irdy) begin
                        x.p = ref_mul(W, 32'(a), 32'(b), s);
                        x.e = e;
                        sq.push_back(x);
                    end
                    if (adv) adv_cnt = e;
                end
                chk({tag, "_drained"}, 64'(sq.size()), 64'd0);
                sweep_done++;
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        vec_t vt [12];
        int   first, cnt, gap;

        vt = '{
            '{8'h70, 8'h08, 1'b0, 16'h0380},
            '{8'hFF, 8'hFF, 1'b0, 16'hFE01},
            '{8'hFF, 8'hFF, 1'b1, 16'h0001},
            '{8'h80, 8'h80, 1'b1, 16'h4000},
            '{8'h80, 8'h7F, 1'b1, 16'hC080},
            '{8'h05, 8'hFD, 1'b1, 16'hFFF1},
            '{8'h7F, 8'h7F, 1'b1, 16'h3F01},
            '{8'h80, 8'hFF, 1'b0, 16'h7F80},
            '{8'h80, 8'hFF, 1'b1, 16'h0080},
            '{8'h01, 8'h80, 1'b1, 16'hFF80},
            '{8'h00, 8'h9C, 1'b1, 16'h0000},
            '{8'h7F, 8'h80, 1'b1, 16'hC080}
        };

        rst = 1'b1; in_valid = 1'b0; in1 = '0; in2 = '0; sgn = 1'b0; out_ready = 1'b0;
        stall_prev = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out", 64'(out), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);

        // Single ops: valid exactly after the second edge, then a bubble drops it.
        foreach (vt[i]) begin
            step(1'b1, vt[i].a, vt[i].b, vt[i].s, 1'b1);
            step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
            chk($sformatf("vec%0d_early", i), 64'(out_valid), 64'd0);
            step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
            chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("vec%0d_out", i), 64'(out), 64'(vt[i].p));
            step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
            chk($sformatf("vec%0d_drop", i), 64'(out_valid), 64'd0);
            chk($sformatf("vec%0d_hold", i), 64'(out), 64'(vt[i].p));
        end

        // Streaming: seven results on consecutive cycles.
        first = -1; cnt = 0; gap = 0;
        for (int c = 0; c < 11; c++) begin
            step(c < 7, 8'h70, 8'(c + 1), 1'b0, 1'b1);
            if (out_valid) begin
                if (first < 0) first = c;
                else if (c != first + cnt) gap++;
                chk("stream_val", 64'(out), 64'(16'h70 * (cnt + 1)));
                cnt++;
            end
        end
        chk("stream_count", 64'(cnt), 64'd7);
        chk("stream_gaps", 64'(gap), 64'd0);
        chk("stream_first", 64'(first), 64'd2);

        // Backpressure: three stalled cycles hold out and block input.
        step(1'b1, 8'h10, 8'h03, 1'b0, 1'b1);
        step(1'b1, 8'h10, 8'h04, 1'b0, 1'b1);
        step(1'b1, 8'h10, 8'h05, 1'b0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            step(1'b1, 8'h10, 8'h06, 1'b0, 1'b0);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_out", 64'(out), 64'h0040);
        end
        step(1'b1, 8'h10, 8'h06, 1'b0, 1'b1);
        repeat (4) step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        chk("bp_drained", 64'(q.size()), 64'd0);

        // Reset with two operand sets in flight.
        step(1'b1, 8'h21, 8'h03, 1'b0, 1'b0);
        step(1'b1, 8'h22, 8'h03, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_mid_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_out", 64'(out), 64'd0);
        q.delete();
        stall_prev = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
            chk("rst_no_stale", 64'(out_valid), 64'd0);
        end

        // Random mixed-mode traffic with random backpressure.
        for (int c = 0; c < 300; c++) begin
            step($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), 1'($urandom),
                 $urandom_range(0, 3) != 0);
        end
        repeat (4) step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        chk("rand_drained", 64'(q.size()), 64'd0);

        sweep_go = 1'b1;
        for (int i = 0; i < 20000 && sweep_done < 9; i++) @(posedge clk);
        chk("sweep_complete", 64'(sweep_done), 64'd9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
